rr_arbiter8: RTL and testbench

RR_ARBITER8 -- requirements
Module: rr_arbiter8

---
 rtl/arb_pkg.sv | 12 +
 rtl/decoder3_8.sv | 11 +
 rtl/rr_arbiter8.sv | 103 ++++++++++
 tb/tb_rr_arbiter8.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/decoder3_8.sv
// 3-to-8 one-hot decoder.
module decoder3_8 (
  input  logic [2:0] in,
  output logic [7:0] out
);

  always_comb begin
    out = 8'b0000_0001 << in;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter with bounded hold time, one bubble cycle
// between grants, and a single-cycle preempt pulse on forced release.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_REQ-1:0]  req,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [IDX_W-1:0]    gnt_idx,
  output logic                gnt_valid,
  output logic                preempt
);

  localparam int unsigned       HOLD_W    = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              preempt_q, preempt_d;

  logic [IDX_W-1:0]   cand;
  logic [IDX_W-1:0]   win_idx;
  logic               win_found;
  logic [NUM_REQ-1:0] dec_out;

  // Priority scan starting at ptr; 3-bit addition gives the mod-8 wrap.
  always_comb begin
    cand      = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = ptr_q + IDX_W'(i);
      if (!win_found && req[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          idx_d   = win_idx;
          hold_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // An owner drop wins over a coincident timeout, so no preempt then.
        if (!req[idx_q]) begin
          state_d = IDLE;
          ptr_d   = idx_q + IDX_W'(1);
        end else if (hold_q == HOLD_LAST) begin
          state_d   = IDLE;
          ptr_d     = idx_q + IDX_W'(1);
          preempt_d = 1'b1;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  decoder3_8 u_dec (
    .in  (idx_q),
    .out (dec_out)
  );

  assign gnt_valid = (state_q == GRANT);
  assign gnt       = dec_out & {NUM_REQ{gnt_valid}};
  assign gnt_idx   = idx_q;
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench: three arbiters (MAX_HOLD 4, 1, 16) share one request
// bus and are compared every cycle against a per-instance behavioural model.
module tb_rr_arbiter8;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] req     = '0;

  logic [2:0][7:0] gnt_a;
  logic [2:0][2:0] idx_a;
  logic [2:0]      vld_a;
  logic [2:0]      pre_a;

  int maxh [3] = '{4, 1, 16};

  int total = 0;
  int bad   = 0;

  int m_owner [3];
  int m_ptr   [3];
  int m_held  [3];
  bit m_pre   [3];
  int run     [3];
  bit prev_v  [3];
  int prev_i  [3];
  int wcnt    [3][8];

  rr_arbiter8 #(.MAX_HOLD(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .req(req),
    .gnt(gnt_a[0]), .gnt_idx(idx_a[0]), .gnt_valid(vld_a[0]), .preempt(pre_a[0])
  );

  rr_arbiter8 #(.MAX_HOLD(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .req(req),
    .gnt(gnt_a[1]), .gnt_idx(idx_a[1]), .gnt_valid(vld_a[1]), .preempt(pre_a[1])
  );

  rr_arbiter8 #(.MAX_HOLD(16)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .req(req),
    .gnt(gnt_a[2]), .gnt_idx(idx_a[2]), .gnt_valid(vld_a[2]), .preempt(pre_a[2])
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_owner[k] = -1;
      m_ptr[k]   = 0;
      m_held[k]  = 0;
      m_pre[k]   = 1'b0;
      run[k]     = 0;
      prev_v[k]  = 1'b0;
      prev_i[k]  = 0;
      for (int i = 0; i < 8; i++) wcnt[k][i] = 0;
    end
  endtask

  // One rising edge of the specified behaviour, in terms of owner / grant length.
  task automatic model_step();
    int c;
    for (int k = 0; k < 3; k++) begin
      m_pre[k] = 1'b0;
      if (m_owner[k] < 0) begin
        if (req != 8'h00) begin
          for (int j = 7; j >= 0; j--) begin
            c = (m_ptr[k] + j) % 8;
            if (req[c]) m_owner[k] = c;
          end
          m_held[k] = 1;
        end
      end else if (!req[m_owner[k]]) begin
        m_ptr[k]   = (m_owner[k] + 1) % 8;
        m_owner[k] = -1;
      end else if (m_held[k] >= maxh[k]) begin
        m_ptr[k]   = (m_owner[k] + 1) % 8;
        m_owner[k] = -1;
        m_pre[k]   = 1'b1;
      end else begin
        m_held[k]++;
      end
    end
  endtask

  task automatic check_all();
    logic [7:0] exp_gnt;
    bit         starved;
    for (int k = 0; k < 3; k++) begin
      exp_gnt = (m_owner[k] >= 0) ? 8'(1 << m_owner[k]) : 8'h00;
      check_eq($sformatf("i%0d gnt", k), 32'(gnt_a[k]), 32'(exp_gnt));
      check_eq($sformatf("i%0d gnt_valid", k), 32'(vld_a[k]), 32'(m_owner[k] >= 0));
      check_eq($sformatf("i%0d preempt", k), 32'(pre_a[k]), 32'(m_pre[k]));
      if (m_owner[k] >= 0)
        check_eq($sformatf("i%0d gnt_idx", k), 32'(idx_a[k]), 32'(m_owner[k]));
      check_eq($sformatf("i%0d onehot0", k), 32'($onehot0(gnt_a[k])), 32'd1);

      if (vld_a[k] && prev_v[k] && (int'(idx_a[k]) == prev_i[k])) run[k]++;
      else run[k] = vld_a[k] ? 1 : 0;
      check_eq($sformatf("i%0d hold_len_over", k), 32'(run[k] > maxh[k]), 32'd0);
      prev_v[k] = vld_a[k];
      prev_i[k] = int'(idx_a[k]);

      starved = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (req[i] && !gnt_a[k][i]) wcnt[k][i]++;
        else wcnt[k][i] = 0;
        if (wcnt[k][i] > 8 * (maxh[k] + 1)) starved = 1'b1;
      end
      check_eq($sformatf("i%0d starvation", k), 32'(starved), 32'd0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (reset_n) model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    req     = '0;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [5:0] vbits;
    logic [5:0] pbits;
    int         n;

    // Idle after reset
    do_reset();
    for (int c = 0; c < 5; c++) begin
      step();
      check_eq("idle gnt", 32'(gnt_a[2]), 32'h0);
    end

    // Alternating 0,2 with drops after three grant cycles (MAX_HOLD=16 instance)
    do_reset();
    req = 8'h05;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (!vld_a[2] && n < 20) begin
        step();
        n++;
      end
      check_eq("rr_wait", 32'(vld_a[2]), 32'd1);
      check_eq($sformatf("rr_idx%0d", g), 32'(idx_a[2]), (g % 2) ? 32'd2 : 32'd0);
      step();
      step();
      req = 8'h05 & ~(8'h01 << idx_a[2]);
      step();
      check_eq("rr_bubble", 32'(vld_a[2]), 32'd0);
      req = 8'h05;
    end

    // Timeout with a constant requester (MAX_HOLD=4 instance)
    do_reset();
    req = 8'h08;
    vbits = '0;
    pbits = '0;
    for (int s = 0; s < 6; s++) begin
      step();
      vbits = {vbits[4:0], vld_a[0]};
      pbits = {pbits[4:0], pre_a[0]};
    end
    check_eq("timeout_valid_seq", 32'(vbits), 32'(6'b111101));
    check_eq("timeout_preempt_seq", 32'(pbits), 32'(6'b000010));
    check_eq("timeout_regrant_idx", 32'(idx_a[0]), 32'd3);

    // Pointer wrap after owner 7 releases
    do_reset();
    req = 8'h80;
    step();
    step();
    check_eq("wrap_owner7", 32'(gnt_a[2]), 32'h80);
    req = 8'h01;
    step();
    req = 8'h81;
    step();
    check_eq("wrap_next_gnt", 32'(gnt_a[2]), 32'h01);

    // Asynchronous reset mid-grant, between clock edges
    do_reset();
    req = 8'hFF;
    step();
    step();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    check_eq("arst_gnt", 32'(gnt_a[2]), 32'h0);
    check_eq("arst_valid", 32'(vld_a[2]), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    req = 8'hFF;
    step();
    check_eq("arst_first_gnt", 32'(gnt_a[2]), 32'h01);

    // Random traffic with slowly varying request lines
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      if (c % 500 == 0) req = 8'($urandom);
      else begin
        for (int i = 0; i < 8; i++)
          if ($urandom_range(5) == 0) req[i] = ~req[i];
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
